cmp_result_monitor: RTL and testbench
=====================================

Name: cmp_result_monitor

Overview:
- Downstream consumer of the 8-bit magnitude comparator's one-hot flags: G (a>b), Q (a==b), L (a<b).
- Qualifies each sample with `valid_in` and debounces the ">=" condition through a four-state hysteresis FSM into a registered `alarm`.
- Keeps saturating occurrence counters and flags illegal (non-one-hot) comparator outputs.

Parameters:
- ASSERT_LEN, 3, consecutive ">=" samples needed to raise `alarm`; legal range 1..255.
- RELEASE_LEN, 2, consecutive "<" samples needed to drop `alarm`; legal range 1..255.
- CNT_W, 8, width of the occurrence counters `ge_count` and `lt_count`.

Ports:
- clk, input, 1, single system clock; all logic on its rising edge.
- reset, input, 1, asynchronous, active-high reset.
- clear, input, 1, synchronous soft clear.
- valid_in, input, 1, flags valid this cycle.
- g_in, input, 1, comparator G (a>b).
- eq_in, input, 1, comparator Q (a==b).
- l_in, input, 1, comparator L (a<b).
- alarm, output, 1, debounced ">=" condition (registered).
- alarm_rise, output, 1, one-cycle pulse when `alarm` goes 0->1.
- alarm_fall, output, 1, one-cycle pulse when `alarm` goes 1->0.
- flag_err, output, 1, one-cycle pulse on an illegal flag combination.
- run_len, output, 8, current consecutive-run counter.
- ge_count, output, CNT_W, accepted ">=" samples, saturating.
- lt_count, output, CNT_W, accepted "<" samples, saturating.

Behaviour:
- Reset (async, active-high):
  - State = BELOW; `run_len` = 0; both counters = 0.
  - `alarm`, `alarm_rise`, `alarm_fall`, `flag_err` = 0.
- Accepted sample: `valid_in`=1, `clear`=0, and {`g_in`,`eq_in`,`l_in`} exactly one-hot.
  - ge = `g_in` | `eq_in`; lt = `l_in`.
  - Cycles with `valid_in`=0 change nothing; runs are not broken by gaps.
- Illegal sample: `valid_in`=1 and flags not one-hot (including 000).
  - `flag_err` pulses the next cycle.
  - State, `run_len` and both counters are unchanged.
- Counters: accepted ge increments `ge_count`; accepted lt increments `lt_count`. Each saturates at 2^CNT_W-1 (no wrap).
- FSM transitions (on accepted samples only):
  - BELOW:
    - ge -> `run_len`=1; next state ARMING, or ACTIVE directly if ASSERT_LEN=1.
    - lt -> stay; `run_len`=0.
  - ARMING:
    - ge -> `run_len`+1; on reaching ASSERT_LEN go ACTIVE with `run_len`=0.
    - lt -> BELOW; `run_len`=0.
  - ACTIVE:
    - ge -> stay.
    - lt -> `run_len`=1; next state RELEASING, or BELOW if RELEASE_LEN=1.
  - RELEASING:
    - lt -> `run_len`+1; on reaching RELEASE_LEN go BELOW with `run_len`=0.
    - ge -> ACTIVE; `run_len`=0.
- Outputs are registered, so latency is one cycle from the accepted sample edge.
  - `alarm` = 1 iff state is ACTIVE or RELEASING.
  - `alarm_rise` is high on the first cycle `alarm` reads 1.
  - `alarm_fall` is high on the first cycle `alarm` reads 0.
- `clear` has priority over `valid_in`:
  - Next cycle: state BELOW, `run_len` 0, counters 0, `alarm` 0.
  - No `alarm_fall` and no `flag_err` pulse; the simultaneous sample is dropped.
- Reset asserted mid-operation returns everything to reset values immediately, with no pulses.

Test Plan (ASSERT_LEN=3, RELEASE_LEN=2, CNT_W=8):
1. Arming with a break: after reset, accepted samples G, Q, L, G, G, Q.
   - `alarm` rises the cycle after the 6th sample, with `alarm_rise` as a single pulse.
   - `ge_count`=5, `lt_count`=1.
2. Release with hysteresis: from ACTIVE, samples L, G, L, L.
   - `alarm` stays 1 through the first three samples.
   - `alarm` drops the cycle after the 4th sample, with a single `alarm_fall` pulse and `run_len`=0.
3. Gaps: G, (`valid_in`=0 for 5 cycles), G, G.
   - `alarm` rises after the 3rd accepted sample.
   - `run_len` holds its value during the gap.
4. Saturation: 300 consecutive accepted Q samples -> `ge_count`=255, `lt_count`=0, `alarm`=1.
5. Illegal flags: `valid_in`=1 with g=1,l=1, then with 000.
   - Two `flag_err` pulses.
   - Counters, state and `run_len` unchanged.
6. Clear and reset:
   - `clear`=1 with a simultaneous L while ACTIVE -> next cycle `alarm`=0, counters 0, and no `alarm_fall`.
   - `reset` asserted mid-ARMING -> outputs zero asynchronously, before the next clock edge.

Source files
------------

// File: rtl/cmp_result_monitor.sv
// Debounces the comparator ">=" condition into a registered alarm with hysteresis,
// counts accepted ge/lt samples (saturating) and flags non-one-hot comparator outputs.
module cmp_result_monitor #(
    parameter int ASSERT_LEN  = 3,
    parameter int RELEASE_LEN = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid_in,
    input  logic             g_in,
    input  logic             eq_in,
    input  logic             l_in,
    output logic             alarm,
    output logic             alarm_rise,
    output logic             alarm_fall,
    output logic             flag_err,
    output logic [7:0]       run_len,
    output logic [CNT_W-1:0] ge_count,
    output logic [CNT_W-1:0] lt_count
);

    // state     | meaning
    // BELOW     | alarm off, no ">=" run in progress
    // ARMING    | alarm off, counting consecutive ">=" samples
    // ACTIVE    | alarm on, no "<" run in progress
    // RELEASING | alarm on, counting consecutive "<" samples
    typedef enum logic [1:0] {BELOW, ARMING, ACTIVE, RELEASING} state_t;

    localparam logic [7:0] ASSERT_LEN_8  = 8'(ASSERT_LEN);
    localparam logic [7:0] RELEASE_LEN_8 = 8'(RELEASE_LEN);

    state_t           state_q, state_d;
    logic [7:0]       run_len_q, run_len_d;
    logic [CNT_W-1:0] ge_count_q, ge_count_d;
    logic [CNT_W-1:0] lt_count_q, lt_count_d;
    logic             alarm_q, alarm_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             err_q, err_d;

    logic       one_hot;
    logic       accept;
    logic       is_ge;
    logic [7:0] run_inc;

    assign one_hot = (g_in & ~eq_in & ~l_in) | (~g_in & eq_in & ~l_in) | (~g_in & ~eq_in & l_in);
    assign accept  = valid_in & ~clear & one_hot;
    assign is_ge   = g_in | eq_in;
    assign run_inc = run_len_q + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= BELOW;
            run_len_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_len_d = run_len_q;
        if (clear) begin
            state_d   = BELOW;
            run_len_d = 8'd0;
        end else if (accept) begin
            case (state_q)
                BELOW: begin
                    if (is_ge) begin
                        if (ASSERT_LEN_8 == 8'd1) begin
                            state_d   = ACTIVE;
                            run_len_d = 8'd0;
                        end else begin
                            state_d   = ARMING;
                            run_len_d = 8'd1;
                        end
                    end else begin
                        run_len_d = 8'd0;
                    end
                end
                ARMING: begin
                    if (is_ge) begin
                        if (run_inc == ASSERT_LEN_8) begin
                            state_d   = ACTIVE;
                            run_len_d = 8'd0;
                        end else begin
                            run_len_d = run_inc;
                        end
                    end else begin
                        state_d   = BELOW;
                        run_len_d = 8'd0;
                    end
                end
                ACTIVE: begin
                    if (!is_ge) begin
                        if (RELEASE_LEN_8 == 8'd1) begin
                            state_d   = BELOW;
                            run_len_d = 8'd0;
                        end else begin
                            state_d   = RELEASING;
                            run_len_d = 8'd1;
                        end
                    end
                end
                RELEASING: begin
                    if (!is_ge) begin
                        if (run_inc == RELEASE_LEN_8) begin
                            state_d   = BELOW;
                            run_len_d = 8'd0;
                        end else begin
                            run_len_d = run_inc;
                        end
                    end else begin
                        state_d   = ACTIVE;
                        run_len_d = 8'd0;
                    end
                end
                default: begin
                    state_d   = BELOW;
                    run_len_d = 8'd0;
                end
            endcase
        end
    end

    // Pulses are derived from the next alarm value so they line up with alarm itself.
    always_comb begin
        alarm_d = (state_d == ACTIVE) || (state_d == RELEASING);
        rise_d  = alarm_d & ~alarm_q;
        fall_d  = ~alarm_d & alarm_q & ~clear;
        err_d   = valid_in & ~clear & ~one_hot;
    end

    always_comb begin
        ge_count_d = ge_count_q;
        lt_count_d = lt_count_q;
        if (clear) begin
            ge_count_d = '0;
            lt_count_d = '0;
        end else if (accept) begin
            if (is_ge && (ge_count_q != '1))
                ge_count_d = ge_count_q + CNT_W'(1);
            if (!is_ge && (lt_count_q != '1))
                lt_count_d = lt_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ge_count_q <= '0;
            lt_count_q <= '0;
            alarm_q    <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ge_count_q <= ge_count_d;
            lt_count_q <= lt_count_d;
            alarm_q    <= alarm_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            err_q      <= err_d;
        end
    end

    assign alarm      = alarm_q;
    assign alarm_rise = rise_q;
    assign alarm_fall = fall_q;
    assign flag_err   = err_q;
    assign run_len    = run_len_q;
    assign ge_count   = ge_count_q;
    assign lt_count   = lt_count_q;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Scoreboard bench for cmp_result_monitor: a behavioural model queues expected
// outputs per driven cycle; directed scenarios add their own spot checks.
module tb_cmp_result_monitor;

    logic       clk = 1'b0;
    logic       reset, clear, valid_in, g_in, eq_in, l_in;
    logic       alarm, alarm_rise, alarm_fall, flag_err;
    logic [7:0] run_len, ge_count, lt_count;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic       alarm;
        logic       rise;
        logic       fall;
        logic       err;
        logic [7:0] run;
        logic [7:0] ge;
        logic [7:0] lt;
    } exp_t;

    exp_t sb[$];

    // reference model: 0=BELOW 1=ARMING 2=ACTIVE 3=RELEASING
    int m_state, m_run, m_ge, m_lt;
    bit m_alarm;

    cmp_result_monitor #(.ASSERT_LEN(3), .RELEASE_LEN(2), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in),
        .g_in(g_in), .eq_in(eq_in), .l_in(l_in),
        .alarm(alarm), .alarm_rise(alarm_rise), .alarm_fall(alarm_fall),
        .flag_err(flag_err), .run_len(run_len), .ge_count(ge_count), .lt_count(lt_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_run = 0; m_ge = 0; m_lt = 0; m_alarm = 0;
        sb.delete();
    endtask

    task automatic model_step(input bit v, input bit g, input bit e, input bit l, input bit c);
        exp_t x;
        bit prev, err;
        prev = m_alarm;
        err  = 0;
        if (c) begin
            m_state = 0; m_run = 0; m_ge = 0; m_lt = 0;
        end else if (v) begin
            if ((int'(g) + int'(e) + int'(l)) != 1) begin
                err = 1;
            end else if (g || e) begin
                if (m_ge < 255) m_ge++;
                if (m_state == 0)      begin m_state = 1; m_run = 1; end
                else if (m_state == 1) begin
                    m_run++;
                    if (m_run == 3) begin m_state = 2; m_run = 0; end
                end
                else if (m_state == 3) begin m_state = 2; m_run = 0; end
            end else begin
                if (m_lt < 255) m_lt++;
                if (m_state == 0 || m_state == 1) begin m_state = 0; m_run = 0; end
                else if (m_state == 2) begin m_state = 3; m_run = 1; end
                else begin
                    m_run++;
                    if (m_run == 2) begin m_state = 0; m_run = 0; end
                end
            end
        end
        m_alarm = (m_state >= 2);
        x.alarm = m_alarm;
        x.rise  = m_alarm && !prev;
        x.fall  = !m_alarm && prev && !c;
        x.err   = err;
        x.run   = 8'(m_run);
        x.ge    = 8'(m_ge);
        x.lt    = 8'(m_lt);
        sb.push_back(x);
    endtask

    // drive one cycle at the falling edge, then compare against the queued expectation
    task automatic drive(input bit v, input bit g, input bit e, input bit l, input bit c);
        exp_t x;
        @(negedge clk);
        valid_in = v; g_in = g; eq_in = e; l_in = l; clear = c;
        model_step(v, g, e, l, c);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        tests++; if (alarm !== x.alarm)      begin failed++; $display("FAIL sb_alarm got %0b want %0b", alarm, x.alarm); end
        tests++; if (alarm_rise !== x.rise)  begin failed++; $display("FAIL sb_rise got %0b want %0b", alarm_rise, x.rise); end
        tests++; if (alarm_fall !== x.fall)  begin failed++; $display("FAIL sb_fall got %0b want %0b", alarm_fall, x.fall); end
        tests++; if (flag_err !== x.err)     begin failed++; $display("FAIL sb_err got %0b want %0b", flag_err, x.err); end
        tests++; if (run_len !== x.run)      begin failed++; $display("FAIL sb_run got %0d want %0d", run_len, x.run); end
        tests++; if (ge_count !== x.ge)      begin failed++; $display("FAIL sb_ge got %0d want %0d", ge_count, x.ge); end
        tests++; if (lt_count !== x.lt)      begin failed++; $display("FAIL sb_lt got %0d want %0d", lt_count, x.lt); end
        valid_in = 0; g_in = 0; eq_in = 0; l_in = 0; clear = 0;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1; clear = 0; valid_in = 0; g_in = 0; eq_in = 0; l_in = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({alarm, alarm_rise, alarm_fall, flag_err, run_len, ge_count, lt_count} !== 28'd0) begin
            failed++; $display("FAIL reset_state got %0b%0b%0b%0b run %0d ge %0d lt %0d want all 0",
                               alarm, alarm_rise, alarm_fall, flag_err, run_len, ge_count, lt_count);
        end
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_arming();
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        tests++; if (alarm !== 1'b0) begin failed++; $display("FAIL arm_early got %0b want 0", alarm); end
        drive(1, 0, 1, 0, 0);
        tests++; if (alarm !== 1'b1 || alarm_rise !== 1'b1) begin
            failed++; $display("FAIL arm_rise got alarm %0b rise %0b want 1 1", alarm, alarm_rise); end
        tests++; if (ge_count !== 8'd5 || lt_count !== 8'd1) begin
            failed++; $display("FAIL arm_counts got ge %0d lt %0d want 5 1", ge_count, lt_count); end
        idle();
        tests++; if (alarm_rise !== 1'b0) begin failed++; $display("FAIL arm_rise_single got %0b want 0", alarm_rise); end
    endtask

    task automatic test_release();
        drive(1, 0, 0, 1, 0);
        tests++; if (alarm !== 1'b1) begin failed++; $display("FAIL rel_hold1 got %0b want 1", alarm); end
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        tests++; if (alarm !== 1'b1 || run_len !== 8'd1) begin
            failed++; $display("FAIL rel_hold3 got alarm %0b run %0d want 1 1", alarm, run_len); end
        drive(1, 0, 0, 1, 0);
        tests++; if (alarm !== 1'b0 || alarm_fall !== 1'b1 || run_len !== 8'd0) begin
            failed++; $display("FAIL rel_drop got alarm %0b fall %0b run %0d want 0 1 0", alarm, alarm_fall, run_len); end
        idle();
        tests++; if (alarm_fall !== 1'b0) begin failed++; $display("FAIL rel_fall_single got %0b want 0", alarm_fall); end
    endtask

    task automatic test_gaps();
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            idle();
            tests++; if (run_len !== 8'd1) begin failed++; $display("FAIL gap_hold got %0d want 1", run_len); end
        end
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        tests++; if (alarm !== 1'b1 || alarm_rise !== 1'b1) begin
            failed++; $display("FAIL gap_rise got alarm %0b rise %0b want 1 1", alarm, alarm_rise); end
    endtask

    task automatic test_saturation();
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++) drive(1, 0, 1, 0, 0);
        tests++; if (ge_count !== 8'd255 || lt_count !== 8'd0 || alarm !== 1'b1) begin
            failed++; $display("FAIL sat got ge %0d lt %0d alarm %0b want 255 0 1", ge_count, lt_count, alarm); end
    endtask

    task automatic test_illegal();
        drive(1, 1, 0, 1, 0);
        tests++; if (flag_err !== 1'b1) begin failed++; $display("FAIL ill_gl got %0b want 1", flag_err); end
        drive(1, 0, 0, 0, 0);
        tests++; if (flag_err !== 1'b1) begin failed++; $display("FAIL ill_000 got %0b want 1", flag_err); end
        idle();
        tests++; if (flag_err !== 1'b0) begin failed++; $display("FAIL ill_end got %0b want 0", flag_err); end
        tests++; if (ge_count !== 8'd255 || lt_count !== 8'd0 || run_len !== 8'd0 || alarm !== 1'b1) begin
            failed++; $display("FAIL ill_hold got ge %0d lt %0d run %0d alarm %0b want 255 0 0 1",
                               ge_count, lt_count, run_len, alarm); end
    endtask

    task automatic test_clear();
        drive(1, 0, 0, 1, 1);
        tests++; if (alarm !== 1'b0 || alarm_fall !== 1'b0 || ge_count !== 8'd0 || lt_count !== 8'd0) begin
            failed++; $display("FAIL clr got alarm %0b fall %0b ge %0d lt %0d want 0 0 0 0",
                               alarm, alarm_fall, ge_count, lt_count); end
    endtask

    task automatic test_async_reset();
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        tests++; if (run_len !== 8'd2) begin failed++; $display("FAIL ar_pre got %0d want 2", run_len); end
        @(negedge clk);
        reset = 1;
        #1;
        tests++; if (run_len !== 8'd0 || ge_count !== 8'd0 || alarm !== 1'b0 || alarm_rise !== 1'b0) begin
            failed++; $display("FAIL ar_async got run %0d ge %0d alarm %0b rise %0b want 0 0 0 0",
                               run_len, ge_count, alarm, alarm_rise); end
        model_reset();
        @(negedge clk);
        reset = 0;
        drive(1, 1, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_arming();
        test_release();
        test_gaps();
        test_saturation();
        test_illegal();
        test_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
